// File: rtl/sync_fifo_pkg.sv
// Shared defaults and helpers for the single-clock FIFO slice.
// Imported by the interface, the storage RAM and the FIFO top.
package sync_fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_ADDR_WIDTH = 8;

    function automatic int fifoDepth(input int addrWidth);
        return 1 << addrWidth;
    endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Handshake bundle between a FIFO producer/consumer (master) and the FIFO (slave).
interface sync_fifo_if
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);

    logic                  fifo_wr_en;
    logic [DATA_WIDTH-1:0] fifo_wr_data;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_wr_err;
    logic                  fifo_rd_err;
    logic [ADDR_WIDTH:0]   data_count;

    modport master (
        output fifo_wr_en, fifo_wr_data, fifo_rd_en,
        input  fifo_rd_data, fifo_full, fifo_empty, fifo_wr_err, fifo_rd_err, data_count
    );

    modport slave (
        input  fifo_wr_en, fifo_wr_data, fifo_rd_en,
        output fifo_rd_data, fifo_full, fifo_empty, fifo_wr_err, fifo_rd_err, data_count
    );

endinterface

// File: rtl/sync_fifo_ram.sv
// Simple dual-port RAM: synchronous write port, synchronous registered read port.
// Contents and read register are deliberately left unreset so this maps onto block RAM.
module sync_fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int DEPTH = fifoDepth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy count, flags and error pulses around a dual-port RAM.
// Read data has one cycle of latency and holds until the next accepted read.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic       clk,
    input  logic       rst_n,
    sync_fifo_if.slave bus
);

    localparam int                  DEPTH      = fifoDepth(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wrPtr_q, wrPtr_d;
    logic [ADDR_WIDTH-1:0] rdPtr_q, rdPtr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  wrErr_q, rdErr_q, rdValid_q;
    logic                  full, empty, wrAcc, rdAcc;
    logic [DATA_WIDTH-1:0] ramRdata;

    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);
    assign wrAcc = bus.fifo_wr_en & ~full;
    assign rdAcc = bus.fifo_rd_en & ~empty;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (wrAcc) begin
            wrPtr_d = wrPtr_q + ADDR_WIDTH'(1);
        end
        if (rdAcc) begin
            rdPtr_d = rdPtr_q + ADDR_WIDTH'(1);
        end
        case ({wrAcc, rdAcc})
            2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
            2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // rdValid_q masks the unreset RAM read register so read data is zero until the first accepted read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            wrErr_q   <= 1'b0;
            rdErr_q   <= 1'b0;
            rdValid_q <= 1'b0;
        end else begin
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            count_q   <= count_d;
            wrErr_q   <= bus.fifo_wr_en & full;
            rdErr_q   <= bus.fifo_rd_en & empty;
            rdValid_q <= rdValid_q | rdAcc;
        end
    end

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (wrAcc),
        .waddr_i (wrPtr_q),
        .wdata_i (bus.fifo_wr_data),
        .re_i    (rdAcc),
        .raddr_i (rdPtr_q),
        .rdata_o (ramRdata)
    );

    assign bus.fifo_rd_data = rdValid_q ? ramRdata : '0;
    assign bus.fifo_full    = full;
    assign bus.fifo_empty   = empty;
    assign bus.fifo_wr_err  = wrErr_q;
    assign bus.fifo_rd_err  = rdErr_q;
    assign bus.data_count   = count_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo: reset, fill, drain, streaming, wrap, async reset, simultaneous access.
module tb_sync_fifo;

    localparam int DW    = 16;
    localparam int AW    = 8;
    localparam int DEPTH = 256;

    logic clk;
    logic rst_n;
    int   checkCount;
    int   errorCount;

    sync_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    sync_fifo #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     tag, observed, observed, expected, expected, $time);
        end
    endtask

    // Drive inputs, let one rising edge pass, and return 1 time unit after it.
    task automatic applyStimulus(input logic wrEn, input logic [DW-1:0] wrData, input logic rdEn);
        bus.fifo_wr_en   = wrEn;
        bus.fifo_wr_data = wrData;
        bus.fifo_rd_en   = rdEn;
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdleReset(input string tag);
        checkOutput({tag, ".empty"}, 32'(bus.fifo_empty), 32'd1);
        checkOutput({tag, ".full"}, 32'(bus.fifo_full), 32'd0);
        checkOutput({tag, ".count"}, 32'(bus.data_count), 32'd0);
        checkOutput({tag, ".rdData"}, 32'(bus.fifo_rd_data), 32'd0);
        checkOutput({tag, ".wrErr"}, 32'(bus.fifo_wr_err), 32'd0);
        checkOutput({tag, ".rdErr"}, 32'(bus.fifo_rd_err), 32'd0);
    endtask

    initial begin
        logic [DW-1:0] word;
        checkCount       = 0;
        errorCount       = 0;
        rst_n            = 1'b0;
        bus.fifo_wr_en   = 1'b0;
        bus.fifo_wr_data = '0;
        bus.fifo_rd_en   = 1'b0;

        // Reset held for 50 cycles
        repeat (50) @(posedge clk);
        #1;
        checkIdleReset("reset");
        rst_n = 1'b1;
        applyStimulus(1'b0, '0, 1'b0);
        checkIdleReset("postReset");

        // Fill 1..256; full only after the last write
        for (int i = 1; i <= DEPTH; i++) begin
            applyStimulus(1'b1, DW'(i), 1'b0);
            checkOutput("fill.count", 32'(bus.data_count), 32'(i));
            checkOutput("fill.full", 32'(bus.fifo_full), (i == DEPTH) ? 32'd1 : 32'd0);
        end
        applyStimulus(1'b1, 16'd999, 1'b0);
        checkOutput("overflow.wrErr", 32'(bus.fifo_wr_err), 32'd1);
        checkOutput("overflow.count", 32'(bus.data_count), 32'd256);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("overflow.wrErrPulse", 32'(bus.fifo_wr_err), 32'd0);
        checkOutput("overflow.countHold", 32'(bus.data_count), 32'd256);

        // Drain in order with one cycle of latency
        for (int k = 1; k <= DEPTH; k++) begin
            applyStimulus(1'b0, '0, 1'b1);
            checkOutput("drain.rdData", 32'(bus.fifo_rd_data), 32'(k));
            checkOutput("drain.count", 32'(bus.data_count), 32'(DEPTH - k));
        end
        checkOutput("drain.empty", 32'(bus.fifo_empty), 32'd1);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("underflow.rdErr", 32'(bus.fifo_rd_err), 32'd1);
        checkOutput("underflow.rdDataHold", 32'(bus.fifo_rd_data), 32'd256);
        checkOutput("underflow.count", 32'(bus.data_count), 32'd0);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("underflow.rdErrPulse", 32'(bus.fifo_rd_err), 32'd0);
        checkOutput("underflow.rdDataHold2", 32'(bus.fifo_rd_data), 32'd256);

        // Streaming: write leads read by one cycle, occupancy stays at one
        applyStimulus(1'b1, 16'd1, 1'b0);
        checkOutput("stream.countStart", 32'(bus.data_count), 32'd1);
        for (int j = 1; j <= 200; j++) begin
            applyStimulus(1'b1, DW'(j + 1), 1'b1);
            checkOutput("stream.rdData", 32'(bus.fifo_rd_data), 32'(j));
            checkOutput("stream.count", 32'(bus.data_count), 32'd1);
            checkOutput("stream.errs", 32'({bus.fifo_wr_err, bus.fifo_rd_err}), 32'd0);
        end
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("stream.lastRd", 32'(bus.fifo_rd_data), 32'd201);
        checkOutput("stream.countEnd", 32'(bus.data_count), 32'd0);

        // Wrap: three fill/drain rounds starting from a non-zero pointer
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                word = DW'((r + 1) * 1000 + i * 7);
                applyStimulus(1'b1, word, 1'b0);
            end
            checkOutput("wrap.full", 32'(bus.fifo_full), 32'd1);
            for (int i = 0; i < DEPTH; i++) begin
                word = DW'((r + 1) * 1000 + i * 7);
                applyStimulus(1'b0, '0, 1'b1);
                checkOutput("wrap.rdData", 32'(bus.fifo_rd_data), 32'(word));
            end
            checkOutput("wrap.empty", 32'(bus.fifo_empty), 32'd1);
        end

        // Full with both enables: read accepted, write rejected and never stored
        for (int i = 1; i <= DEPTH; i++) begin
            applyStimulus(1'b1, DW'(i), 1'b0);
        end
        applyStimulus(1'b1, 16'hAAAA, 1'b1);
        checkOutput("fullBoth.wrErr", 32'(bus.fifo_wr_err), 32'd1);
        checkOutput("fullBoth.rdErr", 32'(bus.fifo_rd_err), 32'd0);
        checkOutput("fullBoth.count", 32'(bus.data_count), 32'd255);
        checkOutput("fullBoth.rdData", 32'(bus.fifo_rd_data), 32'd1);
        for (int k = 2; k <= DEPTH; k++) begin
            applyStimulus(1'b0, '0, 1'b1);
            checkOutput("fullBoth.drain", 32'(bus.fifo_rd_data), 32'(k));
        end
        checkOutput("fullBoth.empty", 32'(bus.fifo_empty), 32'd1);

        // Empty with both enables: write accepted, read rejected
        applyStimulus(1'b1, 16'h0055, 1'b1);
        checkOutput("emptyBoth.rdErr", 32'(bus.fifo_rd_err), 32'd1);
        checkOutput("emptyBoth.wrErr", 32'(bus.fifo_wr_err), 32'd0);
        checkOutput("emptyBoth.count", 32'(bus.data_count), 32'd1);
        checkOutput("emptyBoth.rdDataHold", 32'(bus.fifo_rd_data), 32'd256);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("emptyBoth.readBack", 32'(bus.fifo_rd_data), 32'h55);

        // Async reset at count 100, asserted between clock edges
        for (int i = 1; i <= 101; i++) begin
            applyStimulus(1'b1, DW'(16'h0100 + i), 1'b0);
        end
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("asyncPre.count", 32'(bus.data_count), 32'd100);
        checkOutput("asyncPre.rdData", 32'(bus.fifo_rd_data), 32'h101);
        bus.fifo_rd_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkIdleReset("asyncReset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b1, 16'hBEEF, 1'b0);
        checkOutput("afterReset.count", 32'(bus.data_count), 32'd1);
        checkOutput("afterReset.empty", 32'(bus.fifo_empty), 32'd0);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("afterReset.rdData", 32'(bus.fifo_rd_data), 32'hBEEF);
        checkOutput("afterReset.countEnd", 32'(bus.data_count), 32'd0);
        applyStimulus(1'b0, '0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
